memory_stage: RTL and testbench
===============================

# memory_stage

MEM stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Consumes the ALU result (as byte address or pass-through value) and store data from EX/MEM, performs byte/half/word loads and stores on an internal data memory, and registers the result into MEM/WB. Also provides a word-wide debug read port for the debug unit.

## Interface
- NB, 32, datapath width
- NB_ADDR, 8, word-address width; memory depth is 2^NB_ADDR words
- NB_REG, 5, register-file index width
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance; low = stall or halt, all state held
- i_alu_result  in  NB  ALU result from execute; byte address for loads/stores
- i_write_data  in  NB  rt value to store
- i_mem_read  in  1  load instruction
- i_mem_write  in  1  store instruction
- i_mem_width  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_mem_unsigned  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend
- i_reg_write  in  1  writeback enable, pass-through
- i_mem_to_reg  in  1  writeback select, pass-through
- i_write_reg  in  NB_REG  destination register, pass-through
- i_debug_addr  in  NB_ADDR  debug word address
- o_read_data  out  NB  aligned, extended load data (MEM/WB)
- o_alu_result  out  NB  registered i_alu_result
- o_reg_write, o_mem_to_reg  out  1  registered controls
- o_write_reg  out  NB_REG  registered destination
- o_misaligned  out  1  registered access-fault flag
- o_debug_data  out  NB  registered word at i_debug_addr

## Operation
- Word index = i_alu_result[NB_ADDR+1:2]; upper address bits ignored (address wraps modulo depth). Lane = i_alu_result[1:0]; little-endian, lane k = bits 8k+7:8k.
- Fault: half with lane[0]=1, word with lane≠00, or width 11, while i_mem_read or i_mem_write is set -> o_misaligned=1, store suppressed, o_read_data=0. Otherwise o_misaligned=0.
- Store (i_mem_write, no fault, i_enable): byte writes i_write_data[7:0] to lane; half writes i_write_data[15:0] to lanes lane+1:lane; word writes all 4 lanes. Other lanes unchanged.
- Load (i_mem_read, no fault): extract the byte/half at lane, sign- or zero-extend to NB per i_mem_unsigned; word returned unchanged. Without i_mem_read, o_read_data=0.
- i_mem_read and i_mem_write both set: treated as store only; o_read_data=0.
- Memory array is not reset; contents undefined until written.

## Timing
- Memory read is combinational from the array; all outputs are registers updated on the rising i_clk edge when i_enable=1. Latency inputs -> outputs: 1 cycle.
- Store commits at the same edge that captures its MEM/WB outputs; a load in the following cycle to the same word returns the new data (no bypass needed).
- i_enable=0: no memory write, all MEM/WB outputs hold.
- o_debug_data updates every edge regardless of i_enable, 1-cycle latency, shows post-write contents from the next cycle.
- Reset (asserted at any time, including mid-stall): o_read_data, o_alu_result, o_write_reg, o_debug_data = 0; o_reg_write, o_mem_to_reg, o_misaligned = 0. Memory contents untouched. Release is synchronous to the next edge.

## Structure
- Shared package mem_pkg: width encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10; lane-index constants.
- Sub-module data_memory: 2^NB_ADDR x NB array, 4-bit byte-enable synchronous write, combinational read port plus debug read port. Alignment, byte-enable generation, extension and MEM/WB registers live in memory_stage.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then LW 0x10 -> o_read_data=0xDEADBEEF one cycle after the load is presented; o_debug_data at word 4 = 0xDEADBEEF.
- Over word 0x10 = 0xDEADBEEF: SB 0x55 to 0x12 -> word 0xDE55BEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
- SH 0x8001 to 0x20, LH 0x20 -> 0xFFFF8001, LHU 0x20 -> 0x00008001; SH to 0x21 -> o_misaligned=1, word 8 unchanged.
- Word store with i_enable=0 -> memory and all outputs unchanged; raise i_enable -> store commits on that edge.
- Non-memory op (alu 0x1234, reg_write=1, write_reg=7) -> o_alu_result=0x1234, o_write_reg=7, o_read_data=0, o_misaligned=0.
- Assert i_reset mid-stream -> all outputs 0 immediately (asynchronously); previously stored words still readable afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and its data memory.
//   mem_width_e : access-width encoding carried on i_mem_width
//   LANE_*      : byte-lane indices within a 32-bit little-endian word
//   NUM_LANES   : byte lanes per word (one byte-enable bit per lane)
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_width_e;

    localparam int         NUM_LANES = 4;
    localparam int         LANE_BITS = 8;
    localparam logic [1:0] LANE_0    = 2'd0;
    localparam logic [1:0] LANE_1    = 2'd1;
    localparam logic [1:0] LANE_2    = 2'd2;
    localparam logic [1:0] LANE_3    = 2'd3;

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory for the MEM stage.
//   i_clk          : write clock (rising edge)
//   i_byte_en      : per-lane write enable, lane k = bits 8k+7:8k
//   i_addr         : word address for the write and the main read port
//   i_write_data   : write data, already replicated onto its lanes
//   o_read_data    : combinational read of word i_addr
//   i_debug_addr   : word address for the debug read port
//   o_debug_data   : combinational read of word i_debug_addr
// The array has no reset; contents are undefined until written.
module data_memory
    import mem_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic [NUM_LANES-1:0] i_byte_en,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB-1:0]      i_write_data,
    output logic [NB-1:0]      o_read_data,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic [NB-1:0]      o_debug_data
);

    logic [NB-1:0] mem [0:(2**NB_ADDR)-1];

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_byte_en[k]) begin
                mem[i_addr][k*LANE_BITS +: LANE_BITS] <= i_write_data[k*LANE_BITS +: LANE_BITS];
            end
        end
    end

    assign o_read_data  = mem[i_addr];
    assign o_debug_data = mem[i_debug_addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the five-stage MIPS pipeline.
// Performs byte/half/word loads and stores against data_memory and
// registers the result plus writeback controls into MEM/WB.
//   i_clk, i_reset        : clock, asynchronous active-low reset
//   i_enable              : pipeline advance; low holds MEM/WB and blocks stores
//   i_alu_result          : byte address for loads/stores, else pass-through
//   i_write_data          : store data (rt)
//   i_mem_read/i_mem_write: load / store request
//   i_mem_width           : 00 byte, 01 half, 10 word, 11 reserved
//   i_mem_unsigned        : zero-extend loads when set
//   i_reg_write, i_mem_to_reg, i_write_reg : writeback controls, pass-through
//   i_debug_addr          : debug word address
//   o_read_data           : aligned, extended load data
//   o_alu_result, o_reg_write, o_mem_to_reg, o_write_reg : registered pass-through
//   o_misaligned          : registered access-fault flag
//   o_debug_data          : registered word at i_debug_addr, updated every edge
module memory_stage
    import mem_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_REG  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB-1:0]     i_alu_result,
    input  logic [NB-1:0]     i_write_data,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_mem_width,
    input  logic              i_mem_unsigned,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic [NB_REG-1:0] i_write_reg,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic [NB-1:0]     o_read_data,
    output logic [NB-1:0]     o_alu_result,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic [NB_REG-1:0] o_write_reg,
    output logic              o_misaligned,
    output logic [NB-1:0]     o_debug_data
);

    function automatic logic is_misaligned(input mem_width_e w, input logic [1:0] lane);
        case (w)
            MEM_BYTE: is_misaligned = 1'b0;
            MEM_HALF: is_misaligned = lane[0];
            MEM_WORD: is_misaligned = (lane != LANE_0);
            default:  is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [NUM_LANES-1:0] byte_enable(input mem_width_e w, input logic [1:0] lane);
        case (w)
            MEM_BYTE: byte_enable = 4'b0001 << lane;
            MEM_HALF: byte_enable = lane[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: byte_enable = 4'b1111;
            default:  byte_enable = 4'b0000;
        endcase
    endfunction

    // Copy the store operand onto every lane it could land in, so the byte
    // enables alone decide which lanes are written.
    function automatic logic [NB-1:0] lane_replicate(input mem_width_e w, input logic [NB-1:0] wd);
        case (w)
            MEM_BYTE: lane_replicate = {NUM_LANES{wd[7:0]}};
            MEM_HALF: lane_replicate = {2{wd[15:0]}};
            default:  lane_replicate = wd;
        endcase
    endfunction

    function automatic logic [NB-1:0] load_extend(input logic [NB-1:0] word, input mem_width_e w,
                                                  input logic [1:0] lane, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (w)
            MEM_BYTE: load_extend = {{(NB-8){b[7] & ~uns}}, b};
            MEM_HALF: load_extend = {{(NB-16){h[15] & ~uns}}, h};
            MEM_WORD: load_extend = word;
            default:  load_extend = '0;
        endcase
    endfunction

    // Stage p0: address decode, fault detection, byte enables, memory access
    logic [NB_ADDR-1:0]   word_idx_p0;
    logic [1:0]           lane_p0;
    mem_width_e           width_p0;
    logic                 misaligned_p0;
    logic                 store_p0;
    logic                 load_p0;
    logic [NUM_LANES-1:0] be_p0;
    logic [NB-1:0]        wdata_p0;
    logic [NB-1:0]        rd_word_p0;
    logic [NB-1:0]        dbg_word_p0;
    logic [NB-1:0]        load_data_p0;
    logic                 unused_addr_hi;

    assign word_idx_p0   = i_alu_result[NB_ADDR+1:2];
    assign lane_p0       = i_alu_result[1:0];
    assign width_p0      = mem_width_e'(i_mem_width);
    assign unused_addr_hi = ^i_alu_result[NB-1:NB_ADDR+2];

    assign misaligned_p0 = (i_mem_read | i_mem_write) & is_misaligned(width_p0, lane_p0);
    // A simultaneous read+write is a store only; the store is also held off
    // while stalled or in reset so memory never changes under those.
    assign store_p0      = i_mem_write & ~misaligned_p0 & i_enable & i_reset;
    assign load_p0       = i_mem_read & ~i_mem_write & ~misaligned_p0;
    assign be_p0         = store_p0 ? byte_enable(width_p0, lane_p0) : '0;
    assign wdata_p0      = lane_replicate(width_p0, i_write_data);
    assign load_data_p0  = load_p0 ? load_extend(rd_word_p0, width_p0, lane_p0, i_mem_unsigned) : '0;

    data_memory #(
        .NB      (NB),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_byte_en    (be_p0),
        .i_addr       (word_idx_p0),
        .i_write_data (wdata_p0),
        .o_read_data  (rd_word_p0),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (dbg_word_p0)
    );

    // Stage p1: MEM/WB registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_write_reg  <= '0;
            o_misaligned <= 1'b0;
            o_debug_data <= '0;
        end else begin
            o_debug_data <= dbg_word_p0;
            if (i_enable) begin
                o_read_data  <= load_data_p0;
                o_alu_result <= i_alu_result;
                o_reg_write  <= i_reg_write;
                o_mem_to_reg <= i_mem_to_reg;
                o_write_reg  <= i_write_reg;
                o_misaligned <= misaligned_p0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by
// randomized traffic, compared against a byte-addressed reference model.
module tb_memory_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic [31:0] i_alu_result;
    logic [31:0] i_write_data;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_mem_width;
    logic        i_mem_unsigned;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic [4:0]  i_write_reg;
    logic [7:0]  i_debug_addr;
    logic [31:0] o_read_data;
    logic [31:0] o_alu_result;
    logic        o_reg_write;
    logic        o_mem_to_reg;
    logic [4:0]  o_write_reg;
    logic        o_misaligned;
    logic [31:0] o_debug_data;

    memory_stage #(.NB(32), .NB_ADDR(8), .NB_REG(5)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_alu_result   (i_alu_result),
        .i_write_data   (i_write_data),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_mem_width    (i_mem_width),
        .i_mem_unsigned (i_mem_unsigned),
        .i_reg_write    (i_reg_write),
        .i_mem_to_reg   (i_mem_to_reg),
        .i_write_reg    (i_write_reg),
        .i_debug_addr   (i_debug_addr),
        .o_read_data    (o_read_data),
        .o_alu_result   (o_alu_result),
        .o_reg_write    (o_reg_write),
        .o_mem_to_reg   (o_mem_to_reg),
        .o_write_reg    (o_write_reg),
        .o_misaligned   (o_misaligned),
        .o_debug_data   (o_debug_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a flat byte array (1 KiB) plus a per-word "written" flag.
    logic [7:0]   ref_mem [0:1023];
    logic [255:0] ref_known;

    logic [31:0] exp_rd, exp_alu, exp_dbg;
    logic        exp_rw, exp_m2r, exp_mis;
    logic [4:0]  exp_wreg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] idx);
        ref_word = {ref_mem[{idx, 2'd3}], ref_mem[{idx, 2'd2}], ref_mem[{idx, 2'd1}], ref_mem[{idx, 2'd0}]};
    endfunction

    function automatic logic ref_fault(input logic [1:0] w, input logic [1:0] lane);
        if (w == 2'b00)      ref_fault = 1'b0;
        else if (w == 2'b01) ref_fault = (lane % 2) == 1;
        else if (w == 2'b10) ref_fault = lane != 0;
        else                 ref_fault = 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [9:0] a, input logic [1:0] w, input logic uns);
        logic [31:0] v;
        v = 32'h0;
        if (w == 2'b00) begin
            v = {24'h0, ref_mem[a]};
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (w == 2'b01) begin
            v = {16'h0, ref_mem[a + 10'd1], ref_mem[a]};
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else if (w == 2'b10) begin
            v = ref_word(a[9:2]);
        end
        ref_load = v;
    endfunction

    task automatic ref_store(input logic [9:0] a, input logic [1:0] w, input logic [31:0] wd);
        if (w == 2'b00) begin
            ref_mem[a] = wd[7:0];
        end else if (w == 2'b01) begin
            ref_mem[a]         = wd[7:0];
            ref_mem[a + 10'd1] = wd[15:8];
        end else begin
            for (int k = 0; k < 4; k++) ref_mem[a + 10'(k)] = wd[8*k +: 8];
            ref_known[a[9:2]] = 1'b1;
        end
    endtask

    // One pipeline cycle: present inputs, predict, clock, compare all outputs.
    task automatic drive(input logic en, input logic [31:0] alu, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic [1:0] w, input logic uns,
                         input logic rw, input logic m2r, input logic [4:0] wreg, input logic [7:0] da);
        logic flt;
        logic dbg_valid;
        i_enable = en; i_alu_result = alu; i_write_data = wd; i_mem_read = rd;
        i_mem_write = wr; i_mem_width = w; i_mem_unsigned = uns; i_reg_write = rw;
        i_mem_to_reg = m2r; i_write_reg = wreg; i_debug_addr = da;
        flt       = (rd | wr) && ref_fault(w, alu[1:0]);
        exp_dbg   = ref_word(da);
        dbg_valid = ref_known[da];
        if (en) begin
            exp_rd   = (rd && !wr && !flt) ? ref_load(alu[9:0], w, uns) : 32'h0;
            exp_alu  = alu;
            exp_rw   = rw;
            exp_m2r  = m2r;
            exp_wreg = wreg;
            exp_mis  = flt;
            if (wr && !flt) ref_store(alu[9:0], w, wd);
        end
        @(posedge i_clk);
        #1;
        check("read_data",  o_read_data, exp_rd);
        check("alu_result", o_alu_result, exp_alu);
        check("reg_write",  {31'b0, o_reg_write}, {31'b0, exp_rw});
        check("mem_to_reg", {31'b0, o_mem_to_reg}, {31'b0, exp_m2r});
        check("write_reg",  {27'b0, o_write_reg}, {27'b0, exp_wreg});
        check("misaligned", {31'b0, o_misaligned}, {31'b0, exp_mis});
        if (dbg_valid) check("debug_data", o_debug_data, exp_dbg);
    endtask

    task automatic nop(input logic [7:0] da);
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0, da);
    endtask

    task automatic store(input logic en, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w);
        drive(en, a, wd, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 5'd0, a[9:2]);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] w, input logic uns);
        drive(1'b1, a, 32'h0, 1'b1, 1'b0, w, uns, 1'b1, 1'b1, 5'd3, a[9:2]);
    endtask

    task automatic clear_expected();
        exp_rd = 0; exp_alu = 0; exp_dbg = 0; exp_rw = 0; exp_m2r = 0; exp_mis = 0; exp_wreg = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_data"},  o_read_data, 32'h0);
        check({tag, "_alu_result"}, o_alu_result, 32'h0);
        check({tag, "_ctrl"}, {27'b0, o_reg_write, o_mem_to_reg, o_misaligned, 2'b0}, 32'h0);
        check({tag, "_write_reg"},  {27'b0, o_write_reg}, 32'h0);
        check({tag, "_debug_data"}, o_debug_data, 32'h0);
    endtask

    initial begin
        ref_known = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        clear_expected();
        i_enable = 1'b0; i_alu_result = 0; i_write_data = 0; i_mem_read = 0; i_mem_write = 0;
        i_mem_width = 2'b10; i_mem_unsigned = 0; i_reg_write = 0; i_mem_to_reg = 0;
        i_write_reg = 0; i_debug_addr = 0;

        // Reset state
        i_reset = 1'b1;
        #2 i_reset = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_reset = 1'b1;

        // Fill every word with random data so later reads are all defined
        for (int i = 0; i < 256; i++) store(1'b1, 32'(i * 4), $urandom(), 2'b10);

        // Word store and load
        store(1'b1, 32'h10, 32'hDEADBEEF, 2'b10);
        load(32'h10, 2'b10, 1'b0);
        check("lw_dead", o_read_data, 32'hDEADBEEF);
        check("dbg_word4", o_debug_data, 32'hDEADBEEF);

        // Byte store and signed/unsigned byte loads
        store(1'b1, 32'h12, 32'h00000055, 2'b00);
        load(32'h10, 2'b10, 1'b0);
        check("sb_merge", o_read_data, 32'hDE55BEEF);
        load(32'h13, 2'b00, 1'b0);
        check("lb_sign", o_read_data, 32'hFFFFFFDE);
        load(32'h13, 2'b00, 1'b1);
        check("lbu_zero", o_read_data, 32'h000000DE);

        // Half store, loads, and misaligned half store
        store(1'b1, 32'h20, 32'h12348001, 2'b01);
        load(32'h20, 2'b01, 1'b0);
        check("lh_sign", o_read_data, 32'hFFFF8001);
        load(32'h20, 2'b01, 1'b1);
        check("lhu_zero", o_read_data, 32'h00008001);
        store(1'b1, 32'h21, 32'h0000FFFF, 2'b01);
        check("sh_misaligned", {31'b0, o_misaligned}, 32'h1);
        load(32'h20, 2'b01, 1'b1);
        check("sh_suppressed", o_read_data, 32'h00008001);
        load(32'h22, 2'b10, 1'b0);
        check("lw_misaligned_data", o_read_data, 32'h0);

        // Stalled store must not commit; releasing the stall commits it
        store(1'b1, 32'h30, 32'h11111111, 2'b10);
        store(1'b0, 32'h30, 32'hCAFEF00D, 2'b10);
        load(32'h30, 2'b10, 1'b0);
        check("stall_no_write", o_read_data, 32'h11111111);
        store(1'b1, 32'h30, 32'hCAFEF00D, 2'b10);
        load(32'h30, 2'b10, 1'b0);
        check("stall_release", o_read_data, 32'hCAFEF00D);

        // Non-memory op passes through
        drive(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 5'd7, 8'd4);
        check("pass_alu", o_alu_result, 32'h1234);
        check("pass_wreg", {27'b0, o_write_reg}, 32'd7);
        check("pass_rd_zero", o_read_data, 32'h0);

        // Randomized traffic over a small window of words, with address wrap
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = $urandom();
            a[9:6] = 4'h0;
            drive(($urandom_range(0, 9) != 0), a, $urandom(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  8'($urandom_range(0, 15)));
        end

        // Reset asserted mid-stall clears outputs at once; memory survives
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd9, 8'd4);
        #2 i_reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge i_clk);
        #1 check_all_zero("reset_hold");
        clear_expected();
        @(negedge i_clk) i_reset = 1'b1;
        load(32'h30, 2'b10, 1'b0);
        check("mem_survives_reset", o_read_data, ref_word(8'h0C));
        nop(8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
